// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM type, maximal-length tap masks and the single-step LFSR function (up to 32 bits).
package lfsr_pkg;
    typedef enum logic {IDLE, RUN} lfsr_state_e;
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [23:0] LFSR_TAPS_24 = 24'hE10000;
    localparam logic [31:0] LFSR_TAPS_32 = 32'hA3000000;
    // Bits above the caller's width are don't-care; callers truncate the result.
    function automatic logic [31:0] lfsr_step(input logic [31:0] state, input logic [31:0] taps);
        lfsr_step = {state[30:0], ^(state & taps)};
    endfunction
endpackage

// File: rtl/lfsr_step_unroll.sv
// lfsr_step_unroll: combinational OUT_W-fold application of the Fibonacci LFSR step.
module lfsr_step_unroll
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = 8'hB8,
    parameter int OUT_W = 1
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] state_o
);
    logic [WIDTH-1:0] s;
    always_comb begin
        s = state_i;
        for (int i = 0; i < OUT_W; i++) s = WIDTH'(lfsr_step(32'(s), 32'(TAPS)));
        state_o = s;
    end
endmodule

// File: rtl/lfsr_prng.sv
// lfsr_prng: parametrised LFSR PRNG with valid/ready output and wrap pulse; LFSR_STEP_CNT_EN adds step_cnt.
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = 8'hB8,
    parameter int OUT_W = 1,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [WIDTH-1:0] state_q,
`ifdef LFSR_STEP_CNT_EN
    output logic [WIDTH-1:0] step_cnt,
`endif
    output logic             wrapped
);
    lfsr_state_e fsm_q, fsm_d;
    logic [WIDTH-1:0] state_d, start_q, start_d, seed_v, adv_state;
    logic wrapped_q, wrapped_d, adv;

    lfsr_step_unroll #(.WIDTH(WIDTH), .TAPS(TAPS), .OUT_W(OUT_W)) u_unroll (
        .state_i(state_q),
        .state_o(adv_state)
    );

    assign out_valid = (fsm_q == RUN);
    assign out_data  = state_q[OUT_W-1:0];
    assign wrapped   = wrapped_q;

    // A zero seed would lock the register, so it is swapped for the default.
    always_comb begin
        seed_v    = (seed == '0) ? DEFAULT_SEED : seed;
        adv       = out_valid && out_ready;
        state_d   = load ? seed_v : adv ? adv_state : state_q;
        start_d   = load ? seed_v : start_q;
        fsm_d     = load ? RUN : fsm_q;
        wrapped_d = !load && adv && (adv_state == start_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DEFAULT_SEED;
            start_q   <= DEFAULT_SEED;
            fsm_q     <= IDLE;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            fsm_q     <= fsm_d;
            wrapped_q <= wrapped_d;
        end
    end

`ifdef LFSR_STEP_CNT_EN
    logic [WIDTH-1:0] cnt_q, cnt_d;
    assign step_cnt = cnt_q;
    always_comb cnt_d = load ? '0 : (adv && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif
endmodule
